// File: rtl/ex_mem_redirect_pkg.sv
// Shared definitions for the EX/MEM register and control-flow redirect logic.
package ex_mem_redirect_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SHADOW = 1'b1
    } state_t;

    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] JALR_MASK = 32'hFFFF_FFFE;

endpackage

// File: rtl/ex_mem_redirect_calc.sv
// Combinational branch/jump resolution: take decision, target and link value.
module redirect_calc
    import ex_mem_redirect_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] ext,
    input  logic [31:0] c,
    input  logic        f,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    output logic        take_raw,
    output logic [31:0] target,
    output logic [31:0] link
);

    // Resolve whether control flow changes and where it goes
    always_comb begin
        take_raw = (is_branch & f) | is_jal | is_jalr;
        link     = pc + PC_INC;
        if (is_jalr) begin
            target = c & JALR_MASK;
        end else begin
            target = pc + ext;
        end
    end

endmodule

// File: rtl/ex_mem_redirect.sv
// EX/MEM pipeline register with registered redirect and wrong-path squash FSM.
// Optional statistics counters are enabled by defining EX_REDIRECT_STATS_EN.
module ex_mem_redirect
    import ex_mem_redirect_pkg::*;
#(
    parameter int          SHADOW_DEPTH = 2,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_ext,
    input  logic [31:0] ex_c,
    input  logic        ex_f,
    input  logic [31:0] ex_rD2,
    input  logic        ex_is_branch,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic [4:0]  ex_rd,
    input  logic        ex_rf_we,
    input  logic        ex_ram_we,
    input  logic        mem_stall,
    output logic        mem_valid,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_c,
    output logic [31:0] mem_rD2,
    output logic [4:0]  mem_rd,
    output logic        mem_rf_we,
    output logic        mem_ram_we,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
`ifdef EX_REDIRECT_STATS_EN
    ,
    output logic [31:0] stat_redirects,
    output logic [31:0] stat_squashed
`endif
);

    localparam int CNT_W = (SHADOW_DEPTH < 1) ? 1 : $clog2(SHADOW_DEPTH + 1);

    state_t             state_r;
    logic [CNT_W-1:0]   shadow_cnt_r;
    logic               take_raw_s;
    logic [31:0]        target_s;
    logic [31:0]        link_s;
    logic               squash_s;
    logic               accept_s;
    logic               take_s;
    logic [31:0]        mem_c_next_s;

    redirect_calc u_calc (
        .pc        (ex_pc),
        .ext       (ex_ext),
        .c         (ex_c),
        .f         (ex_f),
        .is_branch (ex_is_branch),
        .is_jal    (ex_is_jal),
        .is_jalr   (ex_is_jalr),
        .take_raw  (take_raw_s),
        .target    (target_s),
        .link      (link_s)
    );

    // Accept/squash qualification and link-value selection
    always_comb begin
        squash_s = (state_r == ST_SHADOW);
        accept_s = ex_valid & ~mem_stall & ~squash_s;
        take_s   = accept_s & take_raw_s;
        if (ex_is_jal | ex_is_jalr) begin
            mem_c_next_s = link_s;
        end else begin
            mem_c_next_s = ex_c;
        end
    end

    // EX/MEM payload register; squashed slots become bubbles with gated enables
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            mem_valid  <= 1'b0;
            mem_pc     <= 32'd0;
            mem_c      <= 32'd0;
            mem_rD2    <= 32'd0;
            mem_rd     <= 5'd0;
            mem_rf_we  <= 1'b0;
            mem_ram_we <= 1'b0;
        end else if (!mem_stall) begin
            mem_valid  <= accept_s;
            mem_pc     <= ex_pc;
            mem_c      <= mem_c_next_s;
            mem_rD2    <= ex_rD2;
            mem_rd     <= ex_rd;
            mem_rf_we  <= ex_rf_we & accept_s;
            mem_ram_we <= ex_ram_we & accept_s;
        end
    end

    // Redirect pulse is registered at take, so a later stall cannot delay it
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC;
        end else begin
            redirect_valid <= take_s;
            if (take_s) begin
                redirect_pc <= target_s;
            end
        end
    end

    // Shadow FSM: counts valid wrong-path instructions; bubbles are not counted
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_r      <= ST_IDLE;
            shadow_cnt_r <= {CNT_W{1'b0}};
        end else if (!mem_stall) begin
            case (state_r)
                ST_IDLE: begin
                    if (take_s && (SHADOW_DEPTH > 0)) begin
                        state_r      <= ST_SHADOW;
                        shadow_cnt_r <= CNT_W'(SHADOW_DEPTH);
                    end
                end
                ST_SHADOW: begin
                    if (ex_valid) begin
                        shadow_cnt_r <= shadow_cnt_r - CNT_W'(1);
                        if (shadow_cnt_r <= CNT_W'(1)) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    shadow_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

`ifdef EX_REDIRECT_STATS_EN
    // Wrapping event counters for redirects issued and valid instructions squashed
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            stat_redirects <= 32'd0;
            stat_squashed  <= 32'd0;
        end else begin
            if (take_s) begin
                stat_redirects <= stat_redirects + 32'd1;
            end
            if (ex_valid & ~mem_stall & squash_s) begin
                stat_squashed <= stat_squashed + 32'd1;
            end
        end
    end
`endif

endmodule
